// File: rtl/mouse_stream_ctrl.sv
// PS/2 mouse bring-up and stream decoder: enables data reporting with retries,
// then turns 3-byte movement packets into a clamped screen cursor and button state.
module mouse_stream_ctrl #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd5_000_000,
  parameter logic [1:0]  MAX_RETRIES = 2'd3,
  parameter logic [9:0]  X_MAX       = 10'd639,
  parameter logic [8:0]  Y_MAX       = 9'd479,
  parameter logic [23:0] BYTE_GAP    = 24'd1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic       send_command,
  output logic [7:0] the_command,
  output logic [9:0] x_position,
  output logic [8:0] y_position,
  output logic       leftClick_pressed,
  output logic       rightClick_pressed,
  output logic       packet_valid,
  output logic       mouse_ready,
  output logic       init_failed
);

  typedef enum logic [2:0] {SEND, WAIT_SENT, WAIT_ACK, B0, B1, B2, FAIL} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  retry_reg;
  logic [23:0] cnt_reg;
  logic [1:0]  hdr_ovf_reg;   // {y_ovf, x_ovf}
  logic [1:0]  hdr_sign_reg;  // {y_sign, x_sign}
  logic [1:0]  hdr_btn_reg;   // {right, left}
  logic [7:0]  dx_byte_reg;
  logic [9:0]  x_reg;
  logic [8:0]  y_reg;
  logic        left_reg, right_reg, valid_reg, send_reg;

  logic        send_next, commit;
  logic        retry_ok, ack_expired, gap_expired, is_ack;
  state_t      retry_state;

  assign retry_ok    = (retry_reg < MAX_RETRIES);
  assign retry_state = retry_ok ? SEND : FAIL;
  assign ack_expired = (cnt_reg == ACK_TIMEOUT - 24'd1);
  assign gap_expired = (cnt_reg == BYTE_GAP - 24'd1);
  assign is_ack      = received_data_en && (received_data == 8'hFA);

  // State register with the retry and shared timeout/byte-gap counters.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= SEND;
      retry_reg    <= 2'd0;
      cnt_reg      <= 24'd0;
      hdr_ovf_reg  <= 2'b00;
      hdr_sign_reg <= 2'b00;
      hdr_btn_reg  <= 2'b00;
      dx_byte_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == SEND)
        retry_reg <= retry_reg + 2'd1;
      if (state_next != state_reg)
        cnt_reg <= 24'd0;
      else if (state_reg == WAIT_ACK || state_reg == B1 || state_reg == B2)
        cnt_reg <= cnt_reg + 24'd1;
      else
        cnt_reg <= 24'd0;
      if (state_reg == B0 && received_data_en && received_data[3]) begin
        hdr_ovf_reg  <= received_data[7:6];
        hdr_sign_reg <= received_data[5:4];
        hdr_btn_reg  <= received_data[1:0];
      end
      if (state_reg == B1 && received_data_en)
        dx_byte_reg <= received_data;
    end
  end

  // A transmit error wins over a simultaneous command_was_sent.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEND:      state_next = WAIT_SENT;
      WAIT_SENT: begin
        if (error_communication_timed_out) state_next = retry_state;
        else if (command_was_sent)         state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (is_ack)           state_next = B0;
        else if (ack_expired) state_next = retry_state;
      end
      B0:        if (received_data_en && received_data[3]) state_next = B1;
      B1: begin
        if (received_data_en) state_next = B2;
        else if (gap_expired) state_next = B0;
      end
      B2: begin
        if (received_data_en) state_next = B0;
        else if (gap_expired) state_next = B0;
      end
      FAIL:      state_next = FAIL;
      default:   state_next = SEND;
    endcase
  end

  always_comb begin
    send_next   = (state_reg == SEND);
    commit      = (state_reg == B2) && received_data_en;
    mouse_ready = (state_reg == B0) || (state_reg == B1) || (state_reg == B2);
    init_failed = (state_reg == FAIL);
  end

  // Movement arithmetic at 12-bit signed width; overflowed axes contribute zero.
  logic signed [11:0] dx_s, dy_s, x_sum, y_sum;
  logic        [9:0]  x_new;
  logic        [8:0]  y_new;

  always_comb begin
    dx_s  = hdr_ovf_reg[0] ? 12'sd0
                           : $signed({{4{hdr_sign_reg[0]}}, dx_byte_reg});
    dy_s  = hdr_ovf_reg[1] ? 12'sd0
                           : $signed({{4{hdr_sign_reg[1]}}, received_data});
    x_sum = $signed({2'b00, x_reg}) + dx_s;
    y_sum = $signed({3'b000, y_reg}) - dy_s;
    if (x_sum < 12'sd0)                        x_new = 10'd0;
    else if (x_sum > $signed({2'b00, X_MAX}))  x_new = X_MAX;
    else                                       x_new = x_sum[9:0];
    if (y_sum < 12'sd0)                        y_new = 9'd0;
    else if (y_sum > $signed({3'b000, Y_MAX})) y_new = Y_MAX;
    else                                       y_new = y_sum[8:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_reg     <= X_MAX >> 1;
      y_reg     <= Y_MAX >> 1;
      left_reg  <= 1'b0;
      right_reg <= 1'b0;
      valid_reg <= 1'b0;
      send_reg  <= 1'b0;
    end else begin
      send_reg  <= send_next;
      valid_reg <= commit;
      if (commit) begin
        x_reg     <= x_new;
        y_reg     <= y_new;
        left_reg  <= hdr_btn_reg[0];
        right_reg <= hdr_btn_reg[1];
      end
    end
  end

  assign send_command       = send_reg;
  assign the_command        = 8'hF4;
  assign x_position         = x_reg;
  assign y_position         = y_reg;
  assign leftClick_pressed  = left_reg;
  assign rightClick_pressed = right_reg;
  assign packet_valid       = valid_reg;

endmodule

// File: tb/tb_mouse_stream_ctrl.sv
// Directed bench for mouse_stream_ctrl: packet table plus handshake, retry,
// resync and reset sequences.
module tb_mouse_stream_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic       send_command;
  logic [7:0] the_command;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       leftClick_pressed, rightClick_pressed, packet_valid;
  logic       mouse_ready, init_failed;

  int total = 0;
  int bad = 0;

  mouse_stream_ctrl #(
    .ACK_TIMEOUT (24'd16),
    .BYTE_GAP    (24'd32)
  ) dut (
    .CLOCK_50                      (CLOCK_50),
    .reset                         (reset),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .send_command                  (send_command),
    .the_command                   (the_command),
    .x_position                    (x_position),
    .y_position                    (y_position),
    .leftClick_pressed             (leftClick_pressed),
    .rightClick_pressed            (rightClick_pressed),
    .packet_valid                  (packet_valid),
    .mouse_ready                   (mouse_ready),
    .init_failed                   (init_failed)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         ex, ey;
    logic       el, er;
  } pkt_t;

  pkt_t vec[14];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int ex, input int ey, input logic el, input logic er);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    $display("pkt %h %h %h -> x=%0d y=%0d L=%0d R=%0d pv=%0d (want %0d,%0d,%0d,%0d)",
             b0, b1, b2, x_position, y_position, leftClick_pressed, rightClick_pressed,
             packet_valid, ex, ey, el, er);
    check("pkt_valid", int'(packet_valid), 1);
    check("pkt_x", int'(x_position), ex);
    check("pkt_y", int'(y_position), ey);
    check("pkt_left", int'(leftClick_pressed), int'(el));
    check("pkt_right", int'(rightClick_pressed), int'(er));
    @(negedge CLOCK_50);
    check("pkt_valid_one_cycle", int'(packet_valid), 0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    received_data_en = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("rst_x", int'(x_position), 319);
    check("rst_y", int'(y_position), 239);
    check("rst_buttons", int'({leftClick_pressed, rightClick_pressed}), 0);
    check("rst_flags", int'({packet_valid, send_command, mouse_ready, init_failed}), 0);
    $display("reset applied: x=%0d y=%0d ready=%0d", x_position, y_position, mouse_ready);
    reset = 1'b0;
  endtask

  // Must directly follow do_reset: expects the first send_command one cycle after release.
  task automatic handshake();
    @(negedge CLOCK_50);
    check("first_send_latency", int'(send_command), 1);
    check("the_command", int'(the_command), 8'hF4);
    received_data    = 8'hFA;   // stray ACK while waiting for transmit completion
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    check("send_one_cycle", int'(send_command), 0);
    command_was_sent = 1'b1;
    @(negedge CLOCK_50);
    command_was_sent = 1'b0;
    check("fa_in_wait_sent_ignored", int'(mouse_ready), 0);
    send_byte(8'hAA);
    check("non_ack_ignored", int'(mouse_ready), 0);
    send_byte(8'hFA);
    $display("handshake: ready=%0d failed=%0d x=%0d y=%0d",
             mouse_ready, init_failed, x_position, y_position);
    check("ready_after_ack", int'(mouse_ready), 1);
    check("not_failed", int'(init_failed), 0);
    check("hs_x", int'(x_position), 319);
    check("hs_y", int'(y_position), 239);
  endtask

  initial begin
    int pulses, last_c, gap;

    vec[0]  = '{8'h08, 8'h0A, 8'h05, 329, 234, 1'b0, 1'b0};
    vec[1]  = '{8'h38, 8'h00, 8'h00,  73, 479, 1'b0, 1'b0};
    vec[2]  = '{8'h38, 8'h00, 8'h00,   0, 479, 1'b0, 1'b0};
    vec[3]  = '{8'h0A, 8'h05, 8'h04,   5, 475, 1'b0, 1'b1};
    vec[4]  = '{8'h39, 8'hF6, 8'hFB,   0, 479, 1'b1, 1'b0};
    vec[5]  = '{8'h48, 8'h7F, 8'h10,   0, 463, 1'b0, 1'b0};
    vec[6]  = '{8'h88, 8'h20, 8'h50,  32, 463, 1'b0, 1'b0};
    vec[7]  = '{8'h0B, 8'hFF, 8'h00, 287, 463, 1'b1, 1'b1};
    vec[8]  = '{8'h08, 8'hFF, 8'h00, 542, 463, 1'b0, 1'b0};
    vec[9]  = '{8'h08, 8'hFF, 8'h00, 639, 463, 1'b0, 1'b0};
    vec[10] = '{8'h08, 8'h00, 8'hFF, 639, 208, 1'b0, 1'b0};
    vec[11] = '{8'h08, 8'h00, 8'hFF, 639,   0, 1'b0, 1'b0};
    vec[12] = '{8'h18, 8'hFF, 8'h00, 638,   0, 1'b0, 1'b0};
    vec[13] = '{8'h28, 8'h00, 8'hFF, 638,   1, 1'b0, 1'b0};

    do_reset();
    handshake();

    for (int i = 0; i < 14; i++)
      send_pkt(vec[i].b0, vec[i].b1, vec[i].b2, vec[i].ex, vec[i].ey, vec[i].el, vec[i].er);

    // Header without sync bit is dropped, next packet decodes normally.
    send_byte(8'h00);
    check("unsynced_no_valid", int'(packet_valid), 0);
    send_pkt(8'h09, 8'h01, 8'h01, 639, 0, 1'b1, 1'b0);

    // Long gap after two bytes drops the partial packet.
    send_byte(8'h08);
    send_byte(8'h50);
    repeat (40) @(negedge CLOCK_50);
    send_byte(8'h38);
    check("gap_resync_no_early_valid", int'(packet_valid), 0);
    send_byte(8'hF6);
    send_pkt_tail: begin
      send_byte(8'hF0);
      $display("gap resync pkt: x=%0d y=%0d pv=%0d", x_position, y_position, packet_valid);
      check("gap_valid", int'(packet_valid), 1);
      check("gap_x", int'(x_position), 629);
      check("gap_y", int'(y_position), 16);
    end

    // Reset in the middle of a packet, then a fresh handshake.
    send_byte(8'h08);
    do_reset();
    handshake();
    send_pkt(8'h08, 8'h01, 8'h01, 320, 238, 1'b0, 1'b0);

    // No ACK ever: first attempt fails by transmit error (coinciding with sent),
    // the other two time out waiting for the ACK.
    do_reset();
    pulses = 0;
    last_c = 0;
    gap = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLOCK_50);
      command_was_sent = 1'b0;
      error_communication_timed_out = 1'b0;
      if (send_command) begin
        pulses++;
        command_was_sent = 1'b1;
        if (pulses == 1) error_communication_timed_out = 1'b1;
        if (pulses == 2) gap = c - last_c;
        last_c = c;
      end
    end
    $display("no-ack run: pulses=%0d gap=%0d failed=%0d ready=%0d",
             pulses, gap, init_failed, mouse_ready);
    check("retry_pulses", pulses, 3);
    check("error_wins_gap", gap, 2);
    check("init_failed", int'(init_failed), 1);
    check("fail_not_ready", int'(mouse_ready), 0);
    send_byte(8'hFA);
    send_byte(8'h09);
    send_byte(8'h05);
    send_byte(8'h05);
    check("fail_terminal", int'(init_failed), 1);
    check("fail_no_valid", int'(packet_valid), 0);
    check("fail_x", int'(x_position), 319);
    check("fail_y", int'(y_position), 239);
    check("fail_no_send", int'(send_command), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
